// File: rtl/riscv_mc_control.sv
// riscv_mc_control: multi-cycle control FSM for the RV32I core.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) around the decoder, ALU,
// register file and PC. It also keeps a retired-instruction counter and a
// memory-timeout watchdog.
//
// Parameters
//   MEM_TIMEOUT  stalled mem_req cycles (1..255) tolerated before FAULT
//   CNT_W        instret width
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   opcode/func3/func7        decoder fields (sampled in DECODE)
//   branch_taken              ALU compare result (used in EXEC)
//   mem_ready                 memory accepted/completed the current request
//   ir_we, pc_we, pc_sel      instruction register / PC controls
//   alu_src_b, alu_op         ALU operand select and operation {op7, func3}
//   reg_we, wb_sel            register-file write strobe and source select
//   mem_req, mem_we, mem_size memory request, store flag, access size
//   state, instret, fault     debug state, retired count, sticky timeout
//
// Build option: define RISCV_ILLEGAL_TRAP_EN to send illegal opcodes to a
// sticky TRAP state; otherwise they retire-free execute as a NOP (PC+4).
module riscv_mc_control #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             alu_src_b,
  output logic [3:0]       alu_op,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             mem_req,
  output logic             mem_we,
  output logic [2:0]       mem_size,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret,
  output logic             fault
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StFault  = 3'd5,
    StTrap   = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    ClsR, ClsI, ClsLd, ClsSt, ClsBr, ClsJal, ClsJalr, ClsLui, ClsAuipc, ClsIll
  } cls_e;

  localparam logic [7:0] WaitLimit = 8'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  cls_e             cls_q, cls_dec;
  logic [2:0]       func3_q;
  logic             func7_5_q;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] instret_q;
  logic             fault_q;
  logic             retire;
  logic             mem_req_raw;

  // Only func7[5] distinguishes SUB/SRA; the other bits are don't-care here.
  logic unused_func7;
  assign unused_func7 = ^{func7[6], func7[4:0]};

  always_comb begin
    unique case (opcode)
      7'b0110011: cls_dec = ClsR;
      7'b0010011: cls_dec = ClsI;
      7'b0000011: cls_dec = ClsLd;
      7'b0100011: cls_dec = ClsSt;
      7'b1100011: cls_dec = ClsBr;
      7'b1101111: cls_dec = ClsJal;
      7'b1100111: cls_dec = ClsJalr;
      7'b0110111: cls_dec = ClsLui;
      7'b0010111: cls_dec = ClsAuipc;
      default:    cls_dec = ClsIll;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = 2'd0;
    alu_src_b   = 1'b0;
    alu_op      = 4'b0000;
    reg_we      = 1'b0;
    wb_sel      = 2'd0;
    mem_req_raw = 1'b0;
    mem_we      = 1'b0;
    mem_size    = 3'd0;
    retire      = 1'b0;

    unique case (state_q)
      StFetch: begin
        mem_req_raw = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (cls_dec == ClsIll) begin
`ifdef RISCV_ILLEGAL_TRAP_EN
          state_d = StTrap;
`else
          pc_we   = 1'b1;  // skip as NOP; pc_sel stays PC+4, no retire
          state_d = StFetch;
`endif
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        unique case (cls_q)
          ClsR:    alu_op = {func7_5_q, func3_q};
          ClsI:    alu_op = {(func3_q == 3'b101) & func7_5_q, func3_q};  // SRAI only
          ClsBr:   alu_op = 4'b1000;
          default: alu_op = 4'b0000;
        endcase
        alu_src_b = !(cls_q == ClsR || cls_q == ClsBr);
        if (cls_q == ClsBr) begin
          pc_we   = 1'b1;
          pc_sel  = {1'b0, branch_taken};
          retire  = 1'b1;
          state_d = StFetch;
        end else if (cls_q == ClsLd || cls_q == ClsSt) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        mem_req_raw = 1'b1;
        mem_we      = (cls_q == ClsSt);
        mem_size    = func3_q;
        if (mem_ready) begin
          if (cls_q == ClsSt) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end
      end
      StWb: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = StFetch;
        unique case (cls_q)
          ClsLd:   wb_sel = 2'd1;
          ClsJal:  begin wb_sel = 2'd2; pc_sel = 2'd1; end
          ClsJalr: begin wb_sel = 2'd2; pc_sel = 2'd2; end
          ClsLui:  wb_sel = 2'd3;
          default: wb_sel = 2'd0;
        endcase
      end
      StFault, StTrap: ;
      default: state_d = StFault;
    endcase

    // Stall watchdog; a ready arriving on the limit cycle wins.
    if (mem_req_raw && !mem_ready) begin
      wait_d = wait_q + 8'd1;
      if (wait_q == WaitLimit) begin
        state_d = StFault;
      end
    end else begin
      wait_d = 8'd0;
    end

    mem_req = mem_req_raw;
    if (rst) begin
      ir_we   = 1'b0;
      pc_we   = 1'b0;
      reg_we  = 1'b0;
      mem_req = 1'b0;
      mem_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      cls_q     <= ClsR;
      func3_q   <= 3'd0;
      func7_5_q <= 1'b0;
      wait_q    <= 8'd0;
      instret_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == StDecode) begin
        cls_q     <= cls_dec;
        func3_q   <= func3;
        func7_5_q <= func7[5];
      end
      if (retire) begin
        instret_q <= instret_q + 1'b1;  // wraps silently
      end
      if (state_d == StFault) begin
        fault_q <= 1'b1;
      end
    end
  end

  assign state   = state_q;
  assign instret = instret_q;
  assign fault   = fault_q;

endmodule
